// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the byte-lane data memory.
//   - access size encodings (SZ_*)
//   - clear/run FSM state type and state constants
//   - calc_be:       byte-enable mask from access size and lane offset
//   - is_misaligned: alignment-fault flag from access size and lane offset
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t CLEAR = 1'b0;
    localparam state_t RUN   = 1'b1;

    // Returns an 8-lane mask; a 32-bit memory uses only the low 4 bits.
    function automatic logic [7:0] calc_be(input logic [1:0] size,
                                           input logic [2:0] off,
                                           input int unsigned data_w);
        logic [7:0] mask;
        logic [7:0] lanes;
        case (size)
            SZ_BYTE: mask = 8'h01;
            SZ_HALF: mask = 8'h03;
            SZ_WORD: mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        lanes = (data_w == 64) ? 8'hFF : 8'h0F;
        return (mask << off) & lanes;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] off,
                                           input int unsigned data_w);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off[1:0] != 2'b00;
            default: return (data_w != 64) || (off != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational sub-word extraction for loads.
// Shifts the addressed lanes down to bit 0, then sign- or zero-extends
// the byte/half/word to the full width (double passes through).
// Ports:
//   word     in   raw array word
//   offset   in   lane offset within the word
//   size     in   access size (SZ_*)
//   zero_ext in   1 = zero-extend, 0 = sign-extend
//   result   out  extended load value
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]            word,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [1:0]                   size,
    input  logic                         zero_ext,
    output logic [DATA_W-1:0]            result
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: begin
                mask = DATA_W'(8'hFF);
                sign = shifted[7];
            end
            SZ_HALF: begin
                mask = DATA_W'(16'hFFFF);
                sign = shifted[15];
            end
            SZ_WORD: begin
                mask = DATA_W'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = 1'b0;
            end
        endcase
        result = (shifted & mask) | ({DATA_W{sign & ~zero_ext}} & ~mask);
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// data_mem_bytelane: byte-lane data memory for the MEM stage.
// Byte/half/word(/double) stores with lane enables, sign/zero-extended loads
// with one cycle of latency, alignment-fault reporting, and a post-reset
// clear engine that zeroes one word per cycle.
// Optional feature macro: DMEM_PARITY_EN (per-lane even parity, parity_inject
// input and parity_err output).
// Ports:
//   clk, reset (async, active low)
//   mem_read, mem_write, mem_size, mem_unsigned, address, write_data  requests
//   read_data, read_valid   registered load result and its valid pulse
//   misalign                faulted-access pulse
//   ready                   clear finished, requests accepted
module data_mem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
`ifdef DMEM_PARITY_EN
    input  logic              parity_inject,
    output logic              parity_err,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              misalign,
    output logic              ready
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(LANES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [OFF-1:0]   lane_off;
    logic [7:0]       be_full;
    logic [LANES-1:0] be;
    logic             fault, acc_rd, acc_wr;
    logic             unused_bits;

    assign idx         = address[IDX_W+OFF-1:OFF];
    assign lane_off    = address[OFF-1:0];
    assign be_full     = calc_be(mem_size, 3'(lane_off), DATA_W);
    assign be          = be_full[LANES-1:0];
    assign fault       = is_misaligned(mem_size, 3'(lane_off), DATA_W);
    assign acc_rd      = mem_read & ready;
    assign acc_wr      = mem_write & ready;
    assign unused_bits = ^{address[ADDR_W-1:IDX_W+OFF], be_full};

    // Clear / run control.
    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            // ready rises together with the write of the last word
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end else begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign ready = ready_q;

    // Single write port shared by the clear engine and stores.
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_word;
    logic [LANES-1:0]  wr_be;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_word = write_data << {lane_off, 3'b000};
        wr_be   = be;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_word = '0;
            wr_be   = '1;
        end else if (acc_wr && !fault) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // Read stage: extraction is combinational from the pre-edge array value,
    // so a same-edge store to the same word is not visible (read-before-write).
    logic [DATA_W-1:0] rd_word, ld_data;
    logic [DATA_W-1:0] read_data_q;
    logic              read_valid_q, misalign_q;

    assign rd_word = mem[idx];

    dmem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .word     (rd_word),
        .offset   (lane_off),
        .size     (mem_size),
        .zero_ext (mem_unsigned),
        .result   (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            read_data_q  <= (acc_rd && !fault) ? ld_data : '0;
            read_valid_q <= acc_rd;
            misalign_q   <= (acc_rd || acc_wr) && fault;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign misalign   = misalign_q;

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par [DEPTH];
    logic [LANES-1:0] wr_par, rd_par;
    logic             wr_inj, par_bad, parity_err_q;

    // Injection only applies to real stores, never to the clear engine.
    assign wr_inj = (state_q == RUN) & parity_inject;

    always_comb begin
        wr_par = '0;
        rd_par = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_par[i] = (^wr_word[8*i +: 8]) ^ wr_inj;
            rd_par[i] = ^rd_word[8*i +: 8];
        end
        par_bad = |(be & (rd_par ^ par[idx]));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) par[wr_idx][i] <= wr_par[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err_q <= 1'b0;
        else        parity_err_q <= acc_rd && !fault && par_bad;
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_data_mem_bytelane.sv
module tb_data_mem_bytelane;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              mem_read, mem_write, mem_unsigned;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              read_valid, misalign, ready;
`ifdef DMEM_PARITY_EN
    logic              parity_inject;
    logic              parity_err;
`endif

    data_mem_bytelane #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
`ifdef DMEM_PARITY_EN
        .parity_inject (parity_inject),
        .parity_err    (parity_err),
`endif
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .misalign     (misalign),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic        exp_mis;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic rd, input logic wr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ev, input logic em, input logic [31:0] ed);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.exp_valid = ev; v.exp_mis = em; v.exp_data = ed;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
        address = '0; write_data = '0;
`ifdef DMEM_PARITY_EN
        parity_inject = 1'b0;
`endif
    endtask

    // Drive one request just after an edge, let it be captured, sample 1 ns after.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        mem_read = rd; mem_write = wr; mem_size = size; mem_unsigned = uns;
        address = addr; write_data = wdata;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Counts edges until ready; holds requests asserted to prove they are ignored.
    task automatic wait_clear(input string name);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        mem_read = 1'b1; mem_write = 1'b1; mem_size = 2'b10;
        address = 32'h0; write_data = 32'hFFFF_FFFF;
        while (!ready && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (read_valid || misalign) seen = 1'b1;
        end
        idle_inputs();
        check({name, "_cycles"}, 64'(cnt), 64'd256);
        check({name, "_no_pulse"}, 64'(seen), 64'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        add("ld_w_3fc",      1, 0, 2'b10, 0, 32'h3FC, 0, 1, 0, 32'h0);
        add("ld_w_000",      1, 0, 2'b10, 0, 32'h000, 0, 1, 0, 32'h0);
        add("st_w_10",       0, 1, 2'b10, 0, 32'h010, 32'h80FF7F01, 0, 0, 32'h0);
        add("ld_bu_11",      1, 0, 2'b00, 1, 32'h011, 0, 1, 0, 32'h0000007F);
        add("ld_bs_13",      1, 0, 2'b00, 0, 32'h013, 0, 1, 0, 32'hFFFFFF80);
        add("ld_hs_12",      1, 0, 2'b01, 0, 32'h012, 0, 1, 0, 32'hFFFF80FF);
        add("ld_hu_12",      1, 0, 2'b01, 1, 32'h012, 0, 1, 0, 32'h000080FF);
        add("ld_bs_10",      1, 0, 2'b00, 0, 32'h010, 0, 1, 0, 32'h00000001);
        add("st_w_20",       0, 1, 2'b10, 0, 32'h020, 32'h11223344, 0, 0, 32'h0);
        add("st_b_21",       0, 1, 2'b00, 0, 32'h021, 32'hFFFFFFAA, 0, 0, 32'h0);
        add("ld_w_20",       1, 0, 2'b10, 0, 32'h020, 0, 1, 0, 32'h1122AA44);
        add("st_w_08",       0, 1, 2'b10, 0, 32'h008, 32'hCAFEF00D, 0, 0, 32'h0);
        add("ld_h_05_mis",   1, 0, 2'b01, 0, 32'h005, 0, 1, 1, 32'h0);
        add("st_w_0a_mis",   0, 1, 2'b10, 0, 32'h00A, 32'h0, 0, 1, 32'h0);
        add("ld_d_08_mis",   1, 0, 2'b11, 0, 32'h008, 0, 1, 1, 32'h0);
        add("ld_w_08_keep",  1, 0, 2'b10, 0, 32'h008, 0, 1, 0, 32'hCAFEF00D);
        add("st_h_0a",       0, 1, 2'b01, 0, 32'h00A, 32'h0000BEEF, 0, 0, 32'h0);
        add("ld_w_08_half",  1, 0, 2'b10, 0, 32'h008, 0, 1, 0, 32'hBEEFF00D);
        add("idle",          0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 32'h0);
        add("st_w_40",       0, 1, 2'b10, 0, 32'h040, 32'h12345678, 0, 0, 32'h0);
        add("rw_w_40_old",   1, 1, 2'b10, 0, 32'h040, 32'hDEADBEEF, 1, 0, 32'h12345678);
        add("ld_w_440_alias", 1, 0, 2'b10, 0, 32'h440, 0, 1, 0, 32'hDEADBEEF);
        add("ld_hu_42",      1, 0, 2'b01, 1, 32'h042, 0, 1, 0, 32'h0000DEAD);
        add("st_b_443",      0, 1, 2'b00, 0, 32'h443, 32'h00000055, 0, 0, 32'h0);
        add("ld_w_40_byte",  1, 0, 2'b10, 0, 32'h040, 0, 1, 0, 32'h55ADBEEF);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_read_valid", 64'(read_valid), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_read_data", 64'(read_data), 64'd0);
`ifdef DMEM_PARITY_EN
        check("rst_parity_err", 64'(parity_err), 64'd0);
`endif

        reset = 1'b1;
        wait_clear("clear");

        foreach (vecs[i]) begin
            issue(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr,
                  vecs[i].wdata);
            check({vecs[i].name, "_valid"}, 64'(read_valid), 64'(vecs[i].exp_valid));
            check({vecs[i].name, "_mis"}, 64'(misalign), 64'(vecs[i].exp_mis));
            check({vecs[i].name, "_data"}, 64'(read_data), 64'(vecs[i].exp_data));
`ifdef DMEM_PARITY_EN
            check({vecs[i].name, "_perr"}, 64'(parity_err), 64'd0);
`endif
        end

        // Reset reasserted mid-clear restarts the clear from word 0.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("midclear_ready_low", 64'(ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midclear_rst_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        wait_clear("reclear");
        issue(1, 0, 2'b10, 0, 32'h040, 0);
        check("reclear_ld_40_valid", 64'(read_valid), 64'd1);
        check("reclear_ld_40_data", 64'(read_data), 64'd0);

`ifdef DMEM_PARITY_EN
        parity_inject = 1'b1;
        mem_write = 1'b1; mem_size = 2'b10; address = 32'h60; write_data = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        idle_inputs();
        issue(1, 0, 2'b10, 0, 32'h060, 0);
        check("par_ld_60_valid", 64'(read_valid), 64'd1);
        check("par_ld_60_data", 64'(read_data), 64'hA5A5A5A5);
        check("par_ld_60_err", 64'(parity_err), 64'd1);
        parity_inject = 1'b1;
        mem_write = 1'b1; mem_size = 2'b00; address = 32'h71; write_data = 32'h3C;
        @(posedge clk);
        #1;
        idle_inputs();
        issue(1, 0, 2'b00, 1, 32'h070, 0);
        check("par_ld_70_err", 64'(parity_err), 64'd0);
        issue(1, 0, 2'b00, 1, 32'h071, 0);
        check("par_ld_71_err", 64'(parity_err), 64'd1);
        check("par_ld_71_data", 64'(read_data), 64'h3C);
        issue(1, 0, 2'b10, 0, 32'h080, 0);
        check("par_ld_80_clean", 64'(parity_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
